// File: rtl/dr_sync_add_sub_pkg.sv
// Shared types, codeword constants, FSM states and digit helpers for the
// clocked dual-rail add/subtract core.
// Dual-rail digit encoding: bit [1] is the true rail, bit [0] is the false rail.
package pa_AsyncCordic;

  // Default operand MSB index for the CORDIC datapath.
  localparam int RW = 15;

  typedef logic [1:0] dual_rail_t;

  localparam dual_rail_t DR_NULL = 2'b00;
  localparam dual_rail_t DR_ZERO = 2'b01;
  localparam dual_rail_t DR_ONE  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADD,
    ST_HOLD,
    ST_RTZ,
    ST_DRAIN
  } dr_add_state_t;

  function automatic logic dr_is_illegal(input dual_rail_t d);
    return d[1] & d[0];
  endfunction

  function automatic logic dr_is_valid(input dual_rail_t d);
    return d[1] ^ d[0];
  endfunction

  function automatic logic dr_is_spacer(input dual_rail_t d);
    return ~(d[1] | d[0]);
  endfunction

  function automatic dual_rail_t dr_encode(input logic v);
    return v ? DR_ONE : DR_ZERO;
  endfunction

endpackage

// File: rtl/dr_sync_add_sub_if.sv
// Four-phase dual-rail bus between the asynchronous stages and the adder.
// Optional signed-overflow output is present only when DR_ADDER_OVERFLOW_EN
// is defined.
interface dr_sync_add_sub_if
  import pa_AsyncCordic::*;
#(
  parameter int SIZE = RW
);

  dual_rail_t [SIZE:0] a;
  dual_rail_t [SIZE:0] b;
  dual_rail_t          carry;
  dual_rail_t          sub;
  logic                in_ack;
  dual_rail_t [SIZE:0] data_o;
  dual_rail_t          c_o;
  logic                out_ack;
  logic                err_o;
`ifdef DR_ADDER_OVERFLOW_EN
  dual_rail_t          ovf_o;

  modport master (
    output a, b, carry, sub, out_ack,
    input  in_ack, data_o, c_o, err_o, ovf_o
  );

  modport slave (
    input  a, b, carry, sub, out_ack,
    output in_ack, data_o, c_o, err_o, ovf_o
  );
`else
  modport master (
    output a, b, carry, sub, out_ack,
    input  in_ack, data_o, c_o, err_o
  );

  modport slave (
    input  a, b, carry, sub, out_ack,
    output in_ack, data_o, c_o, err_o
  );
`endif

endinterface

// File: rtl/dr_sync_add_sub_chunk_adder.sv
// Combinational CHUNK-bit binary ripple adder. msb_sel marks the position of
// the operand MSB inside this chunk, so a partial last chunk reports the
// carry out of the real MSB rather than of the padding above it.
// DR_ADDER_OVERFLOW_EN adds c_msb, the carry into that MSB.
module dr_chunk_adder #(
  parameter int CHUNK = 4,
  parameter int SELW  = 3
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  input  logic [SELW-1:0]  msb_sel,
  output logic [CHUNK-1:0] sum,
`ifdef DR_ADDER_OVERFLOW_EN
  output logic             c_msb,
`endif
  output logic             cout
);

  logic [CHUNK:0] carries;

  // Ripple the carry through the chunk one bit at a time.
  always_comb begin
    carries[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      sum[i]         = a[i] ^ b[i] ^ carries[i];
      carries[i + 1] = (a[i] & b[i]) | (carries[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = carries[msb_sel + SELW'(1)];
`ifdef DR_ADDER_OVERFLOW_EN
  assign c_msb = carries[msb_sel];
`endif

endmodule

// File: rtl/dr_sync_add_sub.sv
// Clocked dual-rail add/subtract core: captures a complete four-phase token,
// adds CHUNK digits per clock through one shared ripple adder, then presents
// a dual-rail result until the consumer acknowledges.
// DR_ADDER_OVERFLOW_EN enables the signed overflow output ovf_o.
module dr_sync_add_sub
  import pa_AsyncCordic::*;
#(
  parameter int SIZE  = RW,
  parameter int CHUNK = 4
) (
  input logic              clk,
  input logic              rst,
  dr_sync_add_sub_if.slave bus
);

  localparam int N        = (SIZE + CHUNK) / CHUNK;
  localparam int KW       = (N > 1) ? $clog2(N) : 1;
  localparam int SELW     = $clog2(CHUNK + 1);
  localparam int LAST_POS = SIZE - (N - 1) * CHUNK;

  dr_add_state_t state_reg, state_next;
  logic [KW-1:0] k_reg, k_next;
  logic [SIZE:0] a_reg, a_next;
  logic [SIZE:0] b_reg, b_next;
  logic [SIZE:0] sum_reg, sum_next;
  logic          carry_reg, carry_next;
  logic          err_reg, err_next;

  logic          all_valid, all_spacer, any_illegal;
  logic [SIZE:0] a_bin, b_bin;

  logic [(1<<KW)-1:0][CHUNK-1:0] a_chunks, b_chunks;
  logic [CHUNK-1:0] chunk_sum;
  logic [SELW-1:0]  msb_sel;
  logic             chunk_cout;
  logic             last_chunk;
  logic [SIZE:0]    sum_upd;

  dual_rail_t [SIZE:0] data_drive;
  dual_rail_t          c_drive;

  // Classify every input digit and extract the true rails as binary.
  always_comb begin
    all_valid   = dr_is_valid(bus.carry) & dr_is_valid(bus.sub);
    all_spacer  = dr_is_spacer(bus.carry) & dr_is_spacer(bus.sub);
    any_illegal = dr_is_illegal(bus.carry) | dr_is_illegal(bus.sub);
    for (int i = 0; i <= SIZE; i++) begin
      all_valid   &= dr_is_valid(bus.a[i]) & dr_is_valid(bus.b[i]);
      all_spacer  &= dr_is_spacer(bus.a[i]) & dr_is_spacer(bus.b[i]);
      any_illegal |= dr_is_illegal(bus.a[i]) | dr_is_illegal(bus.b[i]);
      a_bin[i] = bus.a[i][1];
      b_bin[i] = bus.b[i][1];
    end
  end

  // Slice the latched operands into chunks; digits past SIZE read as zero.
  genvar gi, gj;
  generate
    for (gi = 0; gi < (1 << KW); gi++) begin : g_chunk
      for (gj = 0; gj < CHUNK; gj++) begin : g_bit
        if (gi * CHUNK + gj <= SIZE) begin : g_live
          assign a_chunks[gi][gj] = a_reg[gi*CHUNK+gj];
          assign b_chunks[gi][gj] = b_reg[gi*CHUNK+gj];
        end else begin : g_pad
          assign a_chunks[gi][gj] = 1'b0;
          assign b_chunks[gi][gj] = 1'b0;
        end
      end
    end
  endgenerate

  assign last_chunk = (k_reg == KW'(N - 1));
  assign msb_sel    = last_chunk ? SELW'(LAST_POS) : SELW'(CHUNK - 1);

`ifdef DR_ADDER_OVERFLOW_EN
  logic chunk_cmsb;
  logic ovf_reg, ovf_next;
`endif

  dr_chunk_adder #(
    .CHUNK (CHUNK),
    .SELW  (SELW)
  ) u_chunk_adder (
    .a       (a_chunks[k_reg]),
    .b       (b_chunks[k_reg]),
    .cin     (carry_reg),
    .msb_sel (msb_sel),
    .sum     (chunk_sum),
`ifdef DR_ADDER_OVERFLOW_EN
    .c_msb   (chunk_cmsb),
`endif
    .cout    (chunk_cout)
  );

  // Only the digits belonging to the current chunk take the new sum bits.
  generate
    for (gi = 0; gi <= SIZE; gi++) begin : g_sum
      assign sum_upd[gi] = (k_reg == KW'(gi / CHUNK)) ? chunk_sum[gi%CHUNK] : sum_reg[gi];
    end
  endgenerate

  // Next-state and datapath updates for the four-phase token FSM.
  always_comb begin
    state_next = state_reg;
    k_next     = k_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    sum_next   = sum_reg;
    carry_next = carry_reg;
    err_next   = 1'b0;
`ifdef DR_ADDER_OVERFLOW_EN
    ovf_next   = ovf_reg;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (any_illegal) begin
          err_next   = 1'b1;
          state_next = ST_DRAIN;
        end else if (all_valid) begin
          // Subtract folds into an add of ~b with the carry-in inverted.
          a_next     = a_bin;
          b_next     = b_bin ^ {(SIZE + 1){bus.sub[1]}};
          carry_next = bus.carry[1] ^ bus.sub[1];
          k_next     = '0;
          state_next = ST_ADD;
        end
      end
      ST_ADD: begin
        sum_next   = sum_upd;
        carry_next = chunk_cout;
        if (last_chunk) begin
`ifdef DR_ADDER_OVERFLOW_EN
          ovf_next = chunk_cout ^ chunk_cmsb;
`endif
          state_next = ST_HOLD;
        end else begin
          k_next = k_reg + KW'(1);
        end
      end
      ST_HOLD: begin
        if (bus.out_ack) state_next = ST_RTZ;
      end
      ST_RTZ: begin
        if (!bus.out_ack && all_spacer) state_next = ST_IDLE;
      end
      ST_DRAIN: begin
        if (all_spacer) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any token in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      k_reg     <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      err_reg   <= 1'b0;
`ifdef DR_ADDER_OVERFLOW_EN
      ovf_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      k_reg     <= k_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      sum_reg   <= sum_next;
      carry_reg <= carry_next;
      err_reg   <= err_next;
`ifdef DR_ADDER_OVERFLOW_EN
      ovf_reg   <= ovf_next;
`endif
    end
  end

  // Dual-rail encode the result only while holding; spacer otherwise.
  always_comb begin
    data_drive = '0;
    c_drive    = DR_NULL;
    if (state_reg == ST_HOLD) begin
      for (int i = 0; i <= SIZE; i++) data_drive[i] = dr_encode(sum_reg[i]);
      c_drive = dr_encode(carry_reg);
    end
  end

  assign bus.in_ack = (state_reg != ST_IDLE);
  assign bus.data_o = data_drive;
  assign bus.c_o    = c_drive;
  assign bus.err_o  = err_reg;
`ifdef DR_ADDER_OVERFLOW_EN
  assign bus.ovf_o  = (state_reg == ST_HOLD) ? dr_encode(ovf_reg) : DR_NULL;
`endif

endmodule

// File: tb/tb_dr_sync_add_sub.sv
// Directed bench for dr_sync_add_sub with SIZE=7, CHUNK=4 (two chunks).
// Overflow checks are included when DR_ADDER_OVERFLOW_EN is defined.
module tb_dr_sync_add_sub;
  import pa_AsyncCordic::*;

  localparam int SIZE = 7;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  dr_sync_add_sub_if #(.SIZE(SIZE)) bus ();

  dr_sync_add_sub #(
    .SIZE  (SIZE),
    .CHUNK (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] enc8(input logic [7:0] v);
    logic [15:0] r;
    for (int i = 0; i < 8; i++) r[2*i +: 2] = v[i] ? 2'b10 : 2'b01;
    return r;
  endfunction

  function automatic logic [1:0] enc1(input logic v);
    return v ? 2'b10 : 2'b01;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_spacer();
    bus.a     = '0;
    bus.b     = '0;
    bus.carry = 2'b00;
    bus.sub   = 2'b00;
  endtask

  // One complete token: capture, N-cycle latency, optional hold, RTZ, IDLE.
  task automatic do_token(input string tag, input logic [7:0] av, input logic [7:0] bv,
                          input logic cv, input logic sv, input logic [7:0] exp_d,
                          input logic exp_c, input logic exp_ovf, input int hold);
    bus.a     = enc8(av);
    bus.b     = enc8(bv);
    bus.carry = enc1(cv);
    bus.sub   = enc1(sv);
    #1;
    check({tag, " in_ack pre"}, 32'(bus.in_ack), 32'd0);
    tick();  // E0
    check({tag, " in_ack E0"}, 32'(bus.in_ack), 32'd1);
    check({tag, " data E0"}, 32'(bus.data_o), 32'h0);
    tick();  // E0+1
    check({tag, " data E0+1"}, 32'(bus.data_o), 32'h0);
    tick();  // E0+2
    check({tag, " data"}, 32'(bus.data_o), 32'(enc8(exp_d)));
    check({tag, " c_o"}, 32'(bus.c_o), 32'(enc1(exp_c)));
`ifdef DR_ADDER_OVERFLOW_EN
    check({tag, " ovf_o"}, 32'(bus.ovf_o), 32'(enc1(exp_ovf)));
`else
    if (exp_ovf) $display("token %s: overflow expected, ovf_o not built", tag);
`endif
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, " hold data"}, 32'(bus.data_o), 32'(enc8(exp_d)));
    end
    bus.out_ack = 1'b1;
    drive_spacer();
    tick();
    check({tag, " rtz data"}, 32'(bus.data_o), 32'h0);
    check({tag, " rtz c_o"}, 32'(bus.c_o), 32'h0);
    check({tag, " rtz in_ack"}, 32'(bus.in_ack), 32'd1);
    bus.out_ack = 1'b0;
    tick();
    check({tag, " idle in_ack"}, 32'(bus.in_ack), 32'd0);
    $display("token %s: a=%02h b=%02h carry=%0d sub=%0d expect %02h c=%0d", tag, av, bv, cv, sv,
             exp_d, exp_c);
  endtask

  initial begin
    rst = 1'b1;
    bus.out_ack = 1'b0;
    drive_spacer();
    tick();
    tick();
    check("reset in_ack", 32'(bus.in_ack), 32'd0);
    check("reset data", 32'(bus.data_o), 32'h0);
    check("reset c_o", 32'(bus.c_o), 32'h0);
    check("reset err", 32'(bus.err_o), 32'd0);
    rst = 1'b0;
    tick();

    do_token("add35_1a", 8'h35, 8'h1A, 1'b0, 1'b0, 8'h4F, 1'b0, 1'b0, 0);
    do_token("sub10_01", 8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1, 1'b0, 0);
    do_token("sub01_02", 8'h01, 8'h02, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 0);
    do_token("addff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0);
    do_token("add7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 0);
    do_token("add12_34c", 8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0, 1'b0, 0);
    do_token("sub05_03c", 8'h05, 8'h03, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0, 0);

    // Illegal digit on a[3] while idle.
    drive_spacer();
    bus.a[3] = 2'b11;
    tick();
    check("illegal err", 32'(bus.err_o), 32'd1);
    check("illegal in_ack", 32'(bus.in_ack), 32'd1);
    check("illegal data", 32'(bus.data_o), 32'h0);
    tick();
    check("illegal err pulse", 32'(bus.err_o), 32'd0);
    check("illegal drain in_ack", 32'(bus.in_ack), 32'd1);
    check("illegal drain data", 32'(bus.data_o), 32'h0);
    drive_spacer();
    tick();
    check("illegal release in_ack", 32'(bus.in_ack), 32'd0);
    $display("token illegal: a[3]=11 drained");

    // b arrives three cycles after the other operands; long consumer stall.
    bus.a     = enc8(8'h35);
    bus.carry = enc1(1'b0);
    bus.sub   = enc1(1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("late_b wait in_ack", 32'(bus.in_ack), 32'd0);
      check("late_b wait data", 32'(bus.data_o), 32'h0);
    end
    do_token("late_b", 8'h35, 8'h1A, 1'b0, 1'b0, 8'h4F, 1'b0, 1'b0, 10);

    // Reset in the middle of ADD discards the token.
    bus.a     = enc8(8'hAA);
    bus.b     = enc8(8'h55);
    bus.carry = enc1(1'b0);
    bus.sub   = enc1(1'b0);
    tick();
    check("rst_mid in_ack E0", 32'(bus.in_ack), 32'd1);
    tick();
    check("rst_mid data E0+1", 32'(bus.data_o), 32'h0);
    rst = 1'b1;
    drive_spacer();
    tick();
    check("rst_mid in_ack", 32'(bus.in_ack), 32'd0);
    check("rst_mid data", 32'(bus.data_o), 32'h0);
    check("rst_mid c_o", 32'(bus.c_o), 32'h0);
    check("rst_mid err", 32'(bus.err_o), 32'd0);
    rst = 1'b0;
    tick();
    $display("token rst_mid: discarded");
    do_token("after_rst", 8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0, 1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
